lif_scheduler: RTL and testbench
================================

# lif_scheduler

Time-multiplexed controller that shares one leaky integrate-and-fire update datapath across `N_NEURONS` neurons. Once per timestep it reads each neuron's membrane state and input current and updates the state. For every neuron that fires it emits a spike event over a valid/ready handshake. It sits between the pin-level input logic, which writes per-neuron currents, and the spike consumer, which drives the output pins or a downstream layer.

## Interface
Parameters:
- `N_NEURONS`, 8: number of neurons served; power of two, 2..16.
- `STATE_W`, 8: membrane state width.
- `CUR_W`, 12: input current width.
- `THRESH`, 200: firing threshold, compared against the unsaturated sum.

Ports:
- `clk`  in  1  rising-edge clock; single clock domain.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `tick`  in  1  starts one timestep; accepted only in IDLE.
- `cur_wr`  in  1  current-table write strobe.
- `cur_addr`  in  $clog2(N_NEURONS)  neuron index for the write.
- `cur_data`  in  CUR_W  current value to write.
- `evt_valid`  out  1  spike event pending.
- `evt_ready`  in  1  consumer accepts the event.
- `evt_id`  out  $clog2(N_NEURONS)  index of the neuron that fired.
- `spikes`  out  N_NEURONS  spike vector of the last completed timestep.
- `busy`  out  1  timestep in progress.
- `done`  out  1  one-cycle pulse when a timestep completes.
- `overrun`  out  1  sticky: `tick` arrived while busy; cleared only by reset.

## Operation
- Storage: current table `cur[N]` (CUR_W each), state table `st[N]` (STATE_W each), working spike vector `wspk`.
- Reset clears all tables, `wspk`, `spikes`, and every output to 0. FSM goes to IDLE.
- FSM states: IDLE, UPDATE, EMIT, FINISH.
  - IDLE: if `tick`, set `idx`=0 and `wspk`=0, then go to UPDATE.
  - UPDATE: compute `sum = (st[idx] >> 1) + cur[idx]` at width max(STATE_W,CUR_W)+1. No overflow is possible.
    - If `sum >= THRESH`: write `st[idx]`=0, set `wspk[idx]`, load `evt_id`=`idx`, go to EMIT.
    - Otherwise: write `st[idx]` = min(sum, 2^STATE_W−1). Go to FINISH if `idx`=N−1, else increment `idx` and stay in UPDATE.
  - EMIT: hold `evt_valid`=1 and a stable `evt_id` until `evt_ready`. On the handshake cycle, go to FINISH if `idx`=N−1, else increment `idx` and go to UPDATE.
  - FINISH: `spikes` ← `wspk`, pulse `done`, go to IDLE.
- `busy` = 1 in every state except IDLE.
- Current writes are accepted in every state.
  - If `cur_addr` equals the `idx` being updated in that same cycle, the update uses the old value. The new value is used from the next timestep.
  - Write and tick in the same cycle: the write lands before neuron 0 is read.
- `tick` while `busy` is ignored and sets `overrun`.
- Reset mid-timestep aborts the timestep. Events already emitted are not retracted, and the pending event is dropped.

## Timing
- All outputs are registered.
- `evt_valid` rises the cycle after the firing neuron's UPDATE cycle. It must not drop or change without a handshake.
- A timestep with no spikes: `tick` at cycle 0, UPDATE on cycles 1..N, FINISH on cycle N+1. `done` and the new `spikes` are visible on cycle N+2.
- Each spike adds 1 EMIT cycle plus the consumer stall.
- With `evt_ready` tied high, total latency is N + 2 + (number of spikes) cycles.
- `busy` falls in the same cycle `done` is high.

## Configuration
- `LIF_SCHED_REFRACTORY_EN` defined:
  - A neuron that fired in timestep t skips integration in timestep t+1. Its state stays 0 and it cannot fire.
  - It still takes one UPDATE cycle, so latency is unchanged.
  - Requires an N-bit refractory register, cleared on reset.
- Not defined: every neuron integrates every timestep.

## Structure
- Package `lif_pkg`:
  - FSM state enum.
  - Default widths and `THRESH`.
  - The saturation max constant.
- Sub-module `lif_update`: combinational shared datapath.
  - Inputs: state, current, refractory flag.
  - Outputs: next state, fire.
  - It is instantiated once; the controller owns all sequencing and storage.

## Test plan
- **Sub-threshold leak.** `cur[0]`=100, 10 ticks. `st[0]` takes 100, 150, 175, 187, 193, 196, 198, 199, 199, 199. `spikes[0]` is never set and no event is emitted.
- **Firing and reset.** `cur[3]`=150, 2 ticks. Tick 1: `st`=150, no event. Tick 2: sum 225 ≥ 200, so `evt_id`=3 and `spikes`=8'b0000_1000; `st[3]` returns to 0.
- **Backpressure.**
  - Setup: `cur[1]` = `cur[5]` = 250, with `evt_ready` low for 5 cycles on each event.
  - Required: ids 1 then 5, each held stable while stalled; `done` arrives 10 cycles later than in the unstalled run.
  - Config: with `LIF_SCHED_REFRACTORY_EN`, run the same stimulus and check that neurons 1 and 5 do not fire on the next tick.
- **Overrun.** `tick` pulsed 3 cycles after a tick was accepted. `overrun` rises and stays high, and only one `done` pulse occurs.
- **Same-cycle write.** `cur_wr` to neuron 2 with value 255 during neuron 2's UPDATE cycle (old value 10). That timestep uses 10; the next timestep uses 255.
- **Reset mid-timestep.** `rst_n` asserted while in EMIT. `evt_valid`, `busy`, `spikes` and `st` all read 0 immediately, and the next tick behaves as the first one after reset.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared types and default sizing for the leaky integrate-and-fire scheduler.
package lif_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_UPDATE = 2'd1,
        S_EMIT   = 2'd2,
        S_FINISH = 2'd3
    } lif_state_e;

    localparam int DEF_N_NEURONS = 8;
    localparam int DEF_STATE_W   = 8;
    localparam int DEF_CUR_W     = 12;
    localparam int DEF_THRESH    = 200;

    function automatic int sat_max(input int w);
        return (1 << w) - 1;
    endfunction

    localparam int DEF_ST_MAX = sat_max(DEF_STATE_W);

endpackage

// File: rtl/lif_update.sv
// Combinational leak/integrate/fire datapath shared by all neurons.
module lif_update
    import lif_pkg::*;
#(
    parameter int STATE_W = DEF_STATE_W,
    parameter int CUR_W   = DEF_CUR_W,
    parameter int THRESH  = DEF_THRESH
) (
    input  logic [STATE_W-1:0] st,
    input  logic [CUR_W-1:0]   cur,
    input  logic               refr,
    output logic [STATE_W-1:0] st_nxt,
    output logic               fire
);

    localparam int SUM_W = ((STATE_W > CUR_W) ? STATE_W : CUR_W) + 1;
    localparam logic [SUM_W-1:0] SAT = SUM_W'(sat_max(STATE_W));
    localparam logic [SUM_W-1:0] THR = SUM_W'(THRESH);

    logic [SUM_W-1:0] sum;

    // Threshold is checked on the unsaturated sum; saturation only affects what is stored.
    always_comb begin
        sum    = SUM_W'(st >> 1) + SUM_W'(cur);
        fire   = 1'b0;
        st_nxt = '0;
        if (!refr) begin
            if (sum >= THR) begin
                fire = 1'b1;
            end else if (sum > SAT) begin
                st_nxt = SAT[STATE_W-1:0];
            end else begin
                st_nxt = sum[STATE_W-1:0];
            end
        end
    end

endmodule

// File: rtl/lif_scheduler.sv
// Time-multiplexed LIF controller: one shared update datapath, spike events over valid/ready.
// Optional refractory behaviour is enabled by defining LIF_SCHED_REFRACTORY_EN.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | waiting for tick
// S_UPDATE | integrating neuron idx, one neuron per cycle
// S_EMIT   | holding spike event for neuron idx until evt_ready
// S_FINISH | publishing the timestep's spike vector, pulsing done
module lif_scheduler
    import lif_pkg::*;
#(
    parameter int N_NEURONS = DEF_N_NEURONS,
    parameter int STATE_W   = DEF_STATE_W,
    parameter int CUR_W     = DEF_CUR_W,
    parameter int THRESH    = DEF_THRESH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         tick,
    input  logic                         cur_wr,
    input  logic [$clog2(N_NEURONS)-1:0] cur_addr,
    input  logic [CUR_W-1:0]             cur_data,
    output logic                         evt_valid,
    input  logic                         evt_ready,
    output logic [$clog2(N_NEURONS)-1:0] evt_id,
    output logic [N_NEURONS-1:0]         spikes,
    output logic                         busy,
    output logic                         done,
    output logic                         overrun
);

    localparam int IDX_W = $clog2(N_NEURONS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_NEURONS - 1);

    lif_state_e state, state_nxt;

    logic [IDX_W-1:0]   idx;
    logic [CUR_W-1:0]   cur_tbl [N_NEURONS];
    logic [STATE_W-1:0] st_tbl  [N_NEURONS];
    logic [N_NEURONS-1:0] wspk;
    logic [STATE_W-1:0] st_nxt;
    logic               fire;
    logic               refr;
    logic               idx_last;

    assign idx_last = (idx == IDX_LAST);

`ifdef LIF_SCHED_REFRACTORY_EN
    // Neurons that fired last timestep sit out the current one.
    logic [N_NEURONS-1:0] refr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refr_q <= '0;
        end else if (state == S_FINISH) begin
            refr_q <= wspk;
        end
    end

    assign refr = refr_q[idx];
`else
    assign refr = 1'b0;
`endif

    lif_update #(
        .STATE_W (STATE_W),
        .CUR_W   (CUR_W),
        .THRESH  (THRESH)
    ) u_update (
        .st      (st_tbl[idx]),
        .cur     (cur_tbl[idx]),
        .refr    (refr),
        .st_nxt  (st_nxt),
        .fire    (fire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (tick) state_nxt = S_UPDATE;
            end
            S_UPDATE: begin
                if (fire)          state_nxt = S_EMIT;
                else if (idx_last) state_nxt = S_FINISH;
            end
            S_EMIT: begin
                if (evt_ready) state_nxt = idx_last ? S_FINISH : S_UPDATE;
            end
            S_FINISH: begin
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            wspk      <= '0;
            evt_valid <= 1'b0;
            evt_id    <= '0;
            spikes    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            busy <= (state_nxt != S_IDLE);
            done <= (state == S_FINISH);
            if (tick && (state != S_IDLE)) overrun <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (tick) begin
                        idx  <= '0;
                        wspk <= '0;
                    end
                end
                S_UPDATE: begin
                    if (fire) begin
                        wspk[idx] <= 1'b1;
                        evt_id    <= idx;
                        evt_valid <= 1'b1;
                    end else if (!idx_last) begin
                        idx <= idx + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (evt_ready) begin
                        evt_valid <= 1'b0;
                        if (!idx_last) idx <= idx + 1'b1;
                    end
                end
                S_FINISH: begin
                    spikes <= wspk;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) st_tbl[i] <= '0;
        end else if (state == S_UPDATE) begin
            st_tbl[idx] <= st_nxt;
        end
    end

    // A write to the neuron being updated lands at the edge, so this cycle's update sees the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) cur_tbl[i] <= '0;
        end else if (cur_wr) begin
            cur_tbl[cur_addr] <= cur_data;
        end
    end

endmodule

// File: tb/tb_lif_scheduler.sv
// Directed self-checking bench for lif_scheduler (default 8 neurons, THRESH 200).
module tb_lif_scheduler;

    logic        clk;
    logic        rst_n;
    logic        tick;
    logic        cur_wr;
    logic [2:0]  cur_addr;
    logic [11:0] cur_data;
    logic        evt_valid;
    logic        evt_ready;
    logic [2:0]  evt_id;
    logic [7:0]  spikes;
    logic        busy;
    logic        done;
    logic        overrun;

    int n_chk = 0;
    int n_err = 0;

    int lat;
    int nev;
    int stab_err;
    int ev_ids [8];

    lif_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .cur_wr    (cur_wr),
        .cur_addr  (cur_addr),
        .cur_data  (cur_data),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .spikes    (spikes),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        tick      = 1'b0;
        cur_wr    = 1'b0;
        cur_addr  = '0;
        cur_data  = '0;
        evt_ready = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step();
    endtask

    task automatic write_cur(input logic [2:0] a, input logic [11:0] d);
        cur_wr   = 1'b1;
        cur_addr = a;
        cur_data = d;
        step();
        cur_wr = 1'b0;
    endtask

    // One timestep: tick at cycle 0, lat = cycle on which done is seen.
    task automatic run_step(input int stall, input int wr_cyc, input logic [2:0] wa, input logic [11:0] wd);
        int c, held;
        logic pv, pr;
        logic [2:0] last_id;
        nev = 0; stab_err = 0; lat = -1; held = 0; pv = 1'b0; pr = 1'b0; last_id = '0;
        tick = 1'b1;
        evt_ready = 1'b0;
        step();
        tick = 1'b0;
        c = 1;
        while (c < 200) begin
            if (c == wr_cyc) begin
                cur_wr = 1'b1; cur_addr = wa; cur_data = wd;
            end else begin
                cur_wr = 1'b0;
            end
            if (done) begin
                lat = c;
                break;
            end
            if (pv && !pr && (!evt_valid || evt_id != last_id)) stab_err++;
            if (evt_valid) begin
                if (!pv || pr) begin
                    if (nev < 8) ev_ids[nev] = int'(evt_id);
                    nev++;
                    held = 0;
                    last_id = evt_id;
                end else begin
                    held++;
                end
                evt_ready = (held >= stall);
            end else begin
                evt_ready = 1'b0;
            end
            pv = evt_valid;
            pr = evt_ready;
            step();
            c++;
        end
        cur_wr = 1'b0;
        evt_ready = 1'b0;
        if (lat < 0) chk("step_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int exp_leak [10];
        int ndone;
        int guard;
        exp_leak = '{100, 150, 175, 187, 193, 196, 198, 199, 199, 199};

        do_reset();
        chk("rst_evt_valid", 32'(evt_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_done",      32'(done),      32'd0);
        chk("rst_spikes",    32'(spikes),    32'd0);
        chk("rst_overrun",   32'(overrun),   32'd0);

        // Sub-threshold leak
        write_cur(3'd0, 12'd100);
        for (int t = 0; t < 10; t++) begin
            run_step(0, -1, 3'd0, 12'd0);
            chk("leak_st0", 32'(dut.st_tbl[0]), 32'(exp_leak[t]));
            chk("leak_nev", 32'(nev), 32'd0);
            chk("leak_spk", 32'(spikes), 32'd0);
        end
        chk("leak_lat", 32'(lat), 32'd10);

        // Firing and reset of membrane
        do_reset();
        write_cur(3'd3, 12'd150);
        run_step(0, -1, 3'd0, 12'd0);
        chk("fire1_st3", 32'(dut.st_tbl[3]), 32'd150);
        chk("fire1_nev", 32'(nev), 32'd0);
        run_step(0, -1, 3'd0, 12'd0);
        chk("fire2_nev", 32'(nev), 32'd1);
        chk("fire2_id",  32'(ev_ids[0]), 32'd3);
        chk("fire2_spk", 32'(spikes), 32'h08);
        chk("fire2_st3", 32'(dut.st_tbl[3]), 32'd0);
        chk("fire2_lat", 32'(lat), 32'd11);

        // Backpressure: unstalled reference then 5-cycle stall per event
        do_reset();
        write_cur(3'd1, 12'd250);
        write_cur(3'd5, 12'd250);
        run_step(0, -1, 3'd0, 12'd0);
        chk("bp0_lat", 32'(lat), 32'd12);
        do_reset();
        write_cur(3'd1, 12'd250);
        write_cur(3'd5, 12'd250);
        run_step(5, -1, 3'd0, 12'd0);
        chk("bp_lat",    32'(lat), 32'd22);
        chk("bp_nev",    32'(nev), 32'd2);
        chk("bp_id0",    32'(ev_ids[0]), 32'd1);
        chk("bp_id1",    32'(ev_ids[1]), 32'd5);
        chk("bp_stable", 32'(stab_err), 32'd0);
        chk("bp_spk",    32'(spikes), 32'h22);
        run_step(0, -1, 3'd0, 12'd0);
`ifdef LIF_SCHED_REFRACTORY_EN
        chk("refr_nev", 32'(nev), 32'd0);
        chk("refr_spk", 32'(spikes), 32'h00);
        chk("refr_lat", 32'(lat), 32'd10);
`else
        chk("bp_next_nev", 32'(nev), 32'd2);
        chk("bp_next_spk", 32'(spikes), 32'h22);
        chk("bp_next_lat", 32'(lat), 32'd12);
`endif

        // Overrun
        do_reset();
        evt_ready = 1'b1;
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            if (done) ndone++;
            step();
        end
        chk("ovr_flag",  32'(overrun), 32'd1);
        chk("ovr_ndone", 32'(ndone), 32'd1);
        run_step(0, -1, 3'd0, 12'd0);
        chk("ovr_sticky", 32'(overrun), 32'd1);

        // Same-cycle write during neuron 2's UPDATE (cycle 3)
        do_reset();
        write_cur(3'd2, 12'd10);
        run_step(0, 3, 3'd2, 12'd255);
        chk("scw_st2",  32'(dut.st_tbl[2]), 32'd10);
        chk("scw_spk",  32'(spikes), 32'h00);
        run_step(0, -1, 3'd0, 12'd0);
        chk("scw2_nev", 32'(nev), 32'd1);
        chk("scw2_id",  32'(ev_ids[0]), 32'd2);
        chk("scw2_spk", 32'(spikes), 32'h04);

        // Reset mid-timestep while holding an event
        do_reset();
        write_cur(3'd0, 12'd100);
        write_cur(3'd4, 12'd250);
        run_step(0, -1, 3'd0, 12'd0);
        chk("rmid_pre_spk", 32'(spikes), 32'h10);
        chk("rmid_pre_st0", 32'(dut.st_tbl[0]), 32'd100);
        evt_ready = 1'b0;
        tick = 1'b1;
        step();
        tick = 1'b0;
        guard = 0;
        while (!evt_valid && guard < 20) begin
            step();
            guard++;
        end
        chk("rmid_in_emit", 32'(evt_valid), 32'd1);
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("rmid_evt_valid", 32'(evt_valid), 32'd0);
        chk("rmid_busy",      32'(busy), 32'd0);
        chk("rmid_spikes",    32'(spikes), 32'h00);
        chk("rmid_st0",       32'(dut.st_tbl[0]), 32'd0);
        #3 rst_n = 1'b1;
        step();
        run_step(0, -1, 3'd0, 12'd0);
        chk("rmid_post_nev", 32'(nev), 32'd0);
        chk("rmid_post_lat", 32'(lat), 32'd10);
        write_cur(3'd4, 12'd250);
        run_step(0, -1, 3'd0, 12'd0);
        chk("rmid_post2_id",  32'(ev_ids[0]), 32'd4);
        chk("rmid_post2_lat", 32'(lat), 32'd11);
        chk("rmid_post2_ovr", 32'(overrun), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
